parking_gate_controller: RTL and testbench

Entry/exit barrier controller that sits directly upstream of the slot-allocation block. It synchronizes and debounces the raw entry and exit vehicle sensors, decides whether to admit a car using the allocator's `parking_full` status, and drives the two barrier gates. It produces clean, spaced, single-cycle `car_enter`/`car_leave` pulses, which are the allocator's only event inputs.

---
 rtl/parking_gate_controller.sv | 169 ++++++++++++++++
 tb/tb_parking_gate_controller.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_gate_controller.sv
`default_nettype none
// ============================================================================
// Module   : parking_gate_controller
// Purpose  : Debounced entry/exit barrier control producing spaced
//            car_enter / car_leave pulses for the slot allocator.
// Revision : 1.0 - initial release
// ============================================================================
module parking_gate_controller #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic entry_sensor,
    input  logic exit_sensor,
    input  logic parking_full,
    output logic car_enter,
    output logic car_leave,
    output logic entry_gate_open,
    output logic exit_gate_open,
    output logic entry_denied,
    output logic gate_fault
);

    localparam logic [3:0] C_DEB_LAST = 4'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] C_TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_OPEN    = 2'd1,
        S_HOLDOFF = 2'd2
    } lane_state_t;

    // Lane 0 is the entry lane, lane 1 the exit lane; only the entry lane can be refused.
    logic [1:0] w_sensor;
    logic [1:0] w_full;
    logic [1:0] w_req;
    logic [1:0] w_deny;
    logic [1:0] w_tmo;
    logic [1:0] w_open;

    assign w_sensor = {exit_sensor, entry_sensor};
    assign w_full   = {1'b0, parking_full};

    for (genvar l = 0; l < 2; l++) begin : g_lane
        logic [1:0]  sync_q;
        logic        deb_q;
        logic [3:0]  cnt_q;
        logic        rise_q;
        logic        fall_q;
        lane_state_t state_q;
        logic [7:0]  timer_q;
        logic        req_q;
        logic        deny_q;
        logic        tmo_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                sync_q <= 2'b00;
                deb_q  <= 1'b0;
                cnt_q  <= 4'd0;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                sync_q <= {sync_q[0], w_sensor[l]};
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                if (sync_q[1] == deb_q) begin
                    cnt_q <= 4'd0;
                end else if (cnt_q == C_DEB_LAST) begin
                    deb_q  <= ~deb_q;
                    cnt_q  <= 4'd0;
                    rise_q <= ~deb_q;
                    fall_q <= deb_q;
                end else begin
                    cnt_q <= cnt_q + 4'd1;
                end
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state_q <= S_IDLE;
                timer_q <= 8'd0;
                req_q   <= 1'b0;
                deny_q  <= 1'b0;
                tmo_q   <= 1'b0;
            end else begin
                req_q  <= 1'b0;
                deny_q <= 1'b0;
                tmo_q  <= 1'b0;
                case (state_q)
                    S_IDLE: begin
                        if (rise_q) begin
                            if (w_full[l]) begin
                                deny_q  <= 1'b1;
                                state_q <= S_HOLDOFF;
                            end else begin
                                req_q   <= 1'b1;
                                timer_q <= 8'd0;
                                state_q <= S_OPEN;
                            end
                        end
                    end
                    S_OPEN: begin
                        // A clearing car wins over a timeout landing on the same edge.
                        if (fall_q) begin
                            state_q <= S_IDLE;
                        end else if (timer_q == C_TMO_LAST) begin
                            tmo_q   <= 1'b1;
                            state_q <= S_HOLDOFF;
                        end else begin
                            timer_q <= timer_q + 8'd1;
                        end
                    end
                    S_HOLDOFF: begin
                        if (fall_q) begin
                            state_q <= S_IDLE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end

        assign w_req[l]  = req_q;
        assign w_deny[l] = deny_q;
        assign w_tmo[l]  = tmo_q;
        assign w_open[l] = (state_q == S_OPEN);
    end

    logic car_enter_q;
    logic car_leave_q;
    logic pend_q;
    logic entry_gate_q;
    logic exit_gate_q;
    logic denied_q;
    logic fault_q;

    // Output stage: a coincident exit request is parked one cycle behind car_enter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            car_enter_q  <= 1'b0;
            car_leave_q  <= 1'b0;
            pend_q       <= 1'b0;
            entry_gate_q <= 1'b0;
            exit_gate_q  <= 1'b0;
            denied_q     <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            car_enter_q  <= w_req[0];
            car_leave_q  <= pend_q | (w_req[1] & ~w_req[0]);
            pend_q       <= w_req[1] & w_req[0];
            entry_gate_q <= w_open[0];
            exit_gate_q  <= w_open[1];
            denied_q     <= |w_deny;
            fault_q      <= fault_q | (|w_tmo);
        end
    end

    assign car_enter       = car_enter_q;
    assign car_leave       = car_leave_q;
    assign entry_gate_open = entry_gate_q;
    assign exit_gate_open  = exit_gate_q;
    assign entry_denied    = denied_q;
    assign gate_fault      = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_parking_gate_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_parking_gate_controller
// Purpose  : Self-checking bench for parking_gate_controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_parking_gate_controller;

    localparam int C_DEB = 4;
    localparam int C_TMO = 16;
    localparam int C_NREC = 11;

    logic clk          = 1'b0;
    logic reset_n      = 1'b0;
    logic entry_sensor = 1'b0;
    logic exit_sensor  = 1'b0;
    logic parking_full = 1'b0;
    logic car_enter;
    logic car_leave;
    logic entry_gate_open;
    logic exit_gate_open;
    logic entry_denied;
    logic gate_fault;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    parking_gate_controller #(
        .DEBOUNCE_CYCLES(C_DEB),
        .TIMEOUT_CYCLES (C_TMO)
    ) u_dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .entry_sensor   (entry_sensor),
        .exit_sensor    (exit_sensor),
        .parking_full   (parking_full),
        .car_enter      (car_enter),
        .car_leave      (car_leave),
        .entry_gate_open(entry_gate_open),
        .exit_gate_open (exit_gate_open),
        .entry_denied   (entry_denied),
        .gate_fault     (gate_fault)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model, tracked in output time: a debounced edge shows up at the
    // outputs two edges after the sample run that completes it.
    bit m_raw  [2][2];
    int m_run  [2];
    bit m_deb  [2];
    bit m_rise [2][2];
    bit m_fall [2][2];
    int m_mode [2];     // 0 closed/idle, 1 gate open, 2 waiting for car to clear
    int m_open [2];
    bit m_full_prev;
    bit m_pend;
    bit e_enter, e_leave, e_egate, e_xgate, e_denied, e_fault;

    task automatic model_reset();
        for (int l = 0; l < 2; l++) begin
            m_raw[l][0] = 0; m_raw[l][1] = 0;
            m_rise[l][0] = 0; m_rise[l][1] = 0;
            m_fall[l][0] = 0; m_fall[l][1] = 0;
            m_run[l] = 0; m_deb[l] = 0; m_mode[l] = 0; m_open[l] = 0;
        end
        m_full_prev = 0; m_pend = 0;
        e_enter = 0; e_leave = 0; e_egate = 0; e_xgate = 0; e_denied = 0; e_fault = 0;
    endtask

    task automatic model_step();
        bit sens [2];
        bit req  [2];
        bit r, f, v;
        sens[0] = entry_sensor;
        sens[1] = exit_sensor;
        e_denied = 0;
        for (int l = 0; l < 2; l++) begin
            req[l] = 0;
            r = m_rise[l][1];
            f = m_fall[l][1];
            m_rise[l][1] = m_rise[l][0];
            m_fall[l][1] = m_fall[l][0];
            m_rise[l][0] = 0;
            m_fall[l][0] = 0;
            v = m_raw[l][0];
            m_raw[l][0] = m_raw[l][1];
            m_raw[l][1] = sens[l];
            if (v != m_deb[l]) m_run[l]++;
            else m_run[l] = 0;
            if (m_run[l] == C_DEB) begin
                m_deb[l] = !m_deb[l];
                m_run[l] = 0;
                m_rise[l][0] = m_deb[l];
                m_fall[l][0] = !m_deb[l];
            end
            case (m_mode[l])
                0: if (r) begin
                    if (l == 0 && m_full_prev) begin
                        e_denied = 1;
                        m_mode[l] = 2;
                    end else begin
                        m_mode[l] = 1;
                        m_open[l] = 1;
                        req[l] = 1;
                    end
                end
                1: if (f) m_mode[l] = 0;
                   else if (m_open[l] == C_TMO) begin
                       m_mode[l] = 2;
                       e_fault = 1;
                   end else m_open[l]++;
                default: if (f) m_mode[l] = 0;
            endcase
        end
        m_full_prev = parking_full;
        e_enter = req[0];
        e_leave = m_pend | (req[1] & !req[0]);
        m_pend  = req[0] & req[1];
        e_egate = (m_mode[0] == 1);
        e_xgate = (m_mode[1] == 1);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) model_reset();
            else model_step();
        end
    end

    always @(negedge clk) begin
        if (reset_n)
            check("cycle_model",
                  32'({car_enter, car_leave, entry_gate_open, exit_gate_open, entry_denied, gate_fault}),
                  32'({e_enter, e_leave, e_egate, e_xgate, e_denied, e_fault}));
        else
            check("in_reset",
                  32'({car_enter, car_leave, entry_gate_open, exit_gate_open, entry_denied, gate_fault}),
                  32'd0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        entry_sensor = 1'b0;
        exit_sensor = 1'b0;
        parking_full = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state",
              32'({car_enter, car_leave, entry_gate_open, exit_gate_open, entry_denied, gate_fault}),
              32'd0);
        reset_n = 1'b1;
    endtask

    typedef struct {
        bit ent;
        bit ext;
        bit full;
        int hi;
        int n_enter;
        int n_leave;
        int n_deny;
        int n_eopen;
        int n_xopen;
        bit fault;
    } vec_t;

    vec_t tbl [C_NREC];

    initial begin
        int ce, cl, cd, co, cx, pulses, left_e, left_x;

        //            ent ext full hi  enter leave deny eopen xopen fault
        tbl[0]  = '{1, 0, 0, 12, 1, 0, 0, 12,  0, 0};   // basic entry
        tbl[1]  = '{1, 0, 1, 10, 0, 0, 1,  0,  0, 0};   // full lot
        tbl[2]  = '{0, 1, 0,  3, 0, 0, 0,  0,  0, 0};   // exit glitch
        tbl[3]  = '{1, 0, 0,  3, 0, 0, 0,  0,  0, 0};   // entry glitch
        tbl[4]  = '{1, 1, 0, 12, 1, 1, 0, 12, 12, 0};   // collision
        tbl[5]  = '{1, 0, 0, 40, 1, 0, 0, 16,  0, 1};   // long timeout
        tbl[6]  = '{0, 1, 0,  4, 0, 1, 0,  0,  4, 0};   // minimum accepted pulse
        tbl[7]  = '{1, 0, 0, 16, 1, 0, 0, 16,  0, 0};   // clears on the timeout edge
        tbl[8]  = '{1, 0, 0, 17, 1, 0, 0, 16,  0, 1};   // one cycle too long
        tbl[9]  = '{0, 1, 0, 30, 0, 1, 0,  0, 16, 1};   // exit timeout
        tbl[10] = '{1, 1, 1, 12, 0, 1, 1,  0, 12, 0};   // denied entry with exit

        for (int i = 0; i < C_NREC; i++) begin
            do_reset();
            ce = 0; cl = 0; cd = 0; co = 0; cx = 0;
            parking_full = tbl[i].full;
            entry_sensor = tbl[i].ent;
            exit_sensor  = tbl[i].ext;
            for (int c = 0; c < tbl[i].hi + 40; c++) begin
                if (c == tbl[i].hi) begin
                    entry_sensor = 1'b0;
                    exit_sensor  = 1'b0;
                end
                tick();
                ce += int'(car_enter);
                cl += int'(car_leave);
                cd += int'(entry_denied);
                co += int'(entry_gate_open);
                cx += int'(exit_gate_open);
            end
            check($sformatf("tbl%0d_enter", i), 32'(ce), 32'(tbl[i].n_enter));
            check($sformatf("tbl%0d_leave", i), 32'(cl), 32'(tbl[i].n_leave));
            check($sformatf("tbl%0d_deny",  i), 32'(cd), 32'(tbl[i].n_deny));
            check($sformatf("tbl%0d_eopen", i), 32'(co), 32'(tbl[i].n_eopen));
            check($sformatf("tbl%0d_xopen", i), 32'(cx), 32'(tbl[i].n_xopen));
            check($sformatf("tbl%0d_fault", i), 32'(gate_fault), 32'(tbl[i].fault));
        end

        // Exact open/close latency on the entry lane.
        do_reset();
        entry_sensor = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            tick();
            check($sformatf("lat_enter_t%0d", t), 32'(car_enter), 32'(t == 8));
            check($sformatf("lat_egate_t%0d", t), 32'(entry_gate_open), 32'(t >= 8));
        end
        entry_sensor = 1'b0;
        for (int t = 1; t <= 9; t++) begin
            tick();
            check($sformatf("close_egate_t%0d", t), 32'(entry_gate_open), 32'(t < 8));
        end

        // Simultaneous arrival: enter first, leave one cycle later.
        do_reset();
        entry_sensor = 1'b1;
        exit_sensor  = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            tick();
            check($sformatf("coll_enter_t%0d", t), 32'(car_enter), 32'(t == 8));
            check($sformatf("coll_leave_t%0d", t), 32'(car_leave), 32'(t == 9));
        end
        entry_sensor = 1'b0;
        exit_sensor  = 1'b0;
        repeat (12) tick();

        // Reset lands while both gates are open and car_leave is pending.
        do_reset();
        entry_sensor = 1'b1;
        exit_sensor  = 1'b1;
        repeat (8) tick();
        check("pre_reset_enter", 32'(car_enter), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset",
              32'({car_enter, car_leave, entry_gate_open, exit_gate_open, entry_denied, gate_fault}),
              32'd0);
        entry_sensor = 1'b0;
        exit_sensor  = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        pulses = 0;
        for (int t = 0; t < 20; t++) begin
            tick();
            pulses += int'(car_enter) + int'(car_leave) + int'(entry_gate_open) + int'(exit_gate_open);
        end
        check("post_reset_quiet", 32'(pulses), 32'd0);

        // Random sensor activity, checked every cycle against the model.
        do_reset();
        left_e = 0;
        left_x = 0;
        for (int c = 0; c < 2000; c++) begin
            if (left_e == 0) begin
                entry_sensor = 1'($urandom_range(0, 1));
                left_e = int'($urandom_range(1, 30));
            end
            if (left_x == 0) begin
                exit_sensor = 1'($urandom_range(0, 1));
                left_x = int'($urandom_range(1, 30));
            end
            left_e--;
            left_x--;
            parking_full = ($urandom_range(0, 2) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
